// File: rtl/datapath_pkg.sv
// Shared opcodes, IR field positions, sequencer state and instruction-class
// encodings for the bus-based datapath.
package datapath_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_INC = 5'b11100;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;
  localparam int unsigned RA_HI  = 26;
  localparam int unsigned RA_LO  = 23;
  localparam int unsigned RB_HI  = 22;
  localparam int unsigned RB_LO  = 19;
  localparam int unsigned RC_HI  = 18;
  localparam int unsigned RC_LO  = 15;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3,
    S_E0, S_E1, S_E2, S_E3, S_M0, S_M1, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_RFMT, CLS_IMM, CLS_UNARY, CLS_LD, CLS_ST,
    CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILL
  } class_e;

  // Immediate forms reuse the register-form ALU operation; ldi is an add.
  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    case (op)
      OP_ANDI: imm_alu_op = OP_AND;
      OP_ORI:  imm_alu_op = OP_OR;
      default: imm_alu_op = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/datapath_sequencer_instr_class_decode.sv
// Opcode to instruction-class decoder. mul/div are legal only when
// SEQ_MULDIV_EN is defined; otherwise they decode as illegal.
module instr_class_decode
  import datapath_pkg::*;
(
  input  logic [4:0] opcode,
  output class_e     cls,
  output logic       illegal
);

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:     cls = CLS_RFMT;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:    cls = CLS_IMM;
      OP_NEG, OP_NOT:                      cls = CLS_UNARY;
      OP_LD:                               cls = CLS_LD;
      OP_ST:                               cls = CLS_ST;
`ifdef SEQ_MULDIV_EN
      OP_MUL, OP_DIV:                      cls = CLS_MULDIV;
`else
      OP_MUL, OP_DIV:                      cls = CLS_ILL;
`endif
      OP_NOP:                              cls = CLS_NOP;
      OP_HALT:                             cls = CLS_HALT;
      default:                             cls = CLS_ILL;
    endcase
  end

  assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/datapath_sequencer.sv
// Hardwired fetch/execute control unit for the bus-based datapath.
// Optional mul/div support is enabled by defining SEQ_MULDIV_EN.
module datapath_sequencer
  import datapath_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_done,
  output logic [15:0] r_out,
  output logic [15:0] r_in,
  output logic        hi_out,
  output logic        lo_out,
  output logic        zhigh_out,
  output logic        zlow_out,
  output logic        pc_out,
  output logic        mdr_out,
  output logic        c_out,
  output logic        inport_out,
  output logic        pc_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        mdr_in,
  output logic        mar_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic [4:0]  alu_op,
  output logic        read,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  class_e      cls;
  logic        dec_illegal;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        unused_ir_bits;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign ra     = ir[RA_HI:RA_LO];
  assign rb     = ir[RB_HI:RB_LO];
  assign rc     = ir[RC_HI:RC_LO];
  assign unused_ir_bits = ^ir[RC_LO-1:0];

  instr_class_decode u_decode (
    .opcode  (opcode),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   if (mem_done) state_d = S_F3;
      S_F3:   state_d = S_E0;
      S_E0: begin
        if (dec_illegal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          case (cls)
            CLS_NOP:   state_d = S_F0;
            CLS_HALT:  state_d = S_HALT;
            CLS_UNARY: state_d = S_E2;
            default:   state_d = S_E1;
          endcase
        end
      end
      S_E1:   state_d = S_E2;
      S_E2: begin
        case (cls)
          CLS_LD, CLS_ST: state_d = S_M0;
          CLS_MULDIV:     state_d = S_E3;
          default:        state_d = S_F0;
        endcase
      end
      S_E3:   state_d = S_F0;
      // st loads MDR from the register file unconditionally; ld waits on memory.
      S_M0:   if (cls == CLS_ST || mem_done) state_d = S_M1;
      S_M1:   if (cls != CLS_ST || mem_done) state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    r_out = '0; r_in = '0;
    hi_out = 1'b0; lo_out = 1'b0; zhigh_out = 1'b0; zlow_out = 1'b0;
    pc_out = 1'b0; mdr_out = 1'b0; c_out = 1'b0; inport_out = 1'b0;
    pc_in = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
    mdr_in = 1'b0; mar_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
    alu_op = '0; read = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    case (state_q)
      S_F0: begin pc_out = 1'b1; mar_in = 1'b1; z_in = 1'b1; alu_op = ALU_INC; end
      S_F1: begin zlow_out = 1'b1; pc_in = 1'b1; mem_rd = 1'b1; end
      S_F2: begin mem_rd = 1'b1; read = 1'b1; mdr_in = mem_done; end
      S_F3: begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_E0: begin
        case (cls)
          CLS_RFMT, CLS_IMM, CLS_LD, CLS_ST: begin r_out = 16'h0001 << rb; y_in = 1'b1; end
          CLS_UNARY:  begin r_out = 16'h0001 << rb; alu_op = opcode; z_in = 1'b1; end
          CLS_MULDIV: begin r_out = 16'h0001 << ra; y_in = 1'b1; end
          default: ;
        endcase
      end
      S_E1: begin
        z_in = 1'b1;
        case (cls)
          CLS_RFMT:       begin r_out = 16'h0001 << rc; alu_op = opcode; end
          CLS_IMM:        begin c_out = 1'b1; alu_op = imm_alu_op(opcode); end
          CLS_LD, CLS_ST: begin c_out = 1'b1; alu_op = OP_ADD; end
          CLS_MULDIV:     begin r_out = 16'h0001 << rb; alu_op = opcode; end
          default: ;
        endcase
      end
      S_E2: begin
        zlow_out = 1'b1;
        case (cls)
          CLS_LD, CLS_ST: mar_in = 1'b1;
          CLS_MULDIV:     lo_in  = 1'b1;
          default:        r_in   = 16'h0001 << ra;
        endcase
      end
      S_E3: begin zhigh_out = 1'b1; hi_in = 1'b1; end
      S_M0: begin
        if (cls == CLS_ST) begin
          r_out  = 16'h0001 << ra;
          mdr_in = 1'b1;
        end else begin
          mem_rd = 1'b1; read = 1'b1; mdr_in = mem_done;
        end
      end
      S_M1: begin
        if (cls == CLS_ST) begin
          mem_wr = 1'b1;
        end else begin
          mdr_out = 1'b1; r_in = 16'h0001 << ra;
        end
      end
      default: ;
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: the driver queues the hand-derived
// control word for every cycle it drives; a negedge monitor pops and compares.
module tb_datapath_sequencer;

  localparam logic [4:0] T_LD = 5'b00000, T_ST = 5'b00010, T_ADD = 5'b00011;
  localparam logic [4:0] T_AND = 5'b00101, T_ADDI = 5'b01100, T_ANDI = 5'b01101;
  localparam logic [4:0] T_MUL = 5'b10000, T_NEG = 5'b10001, T_NOP = 5'b11010;
  localparam logic [4:0] T_INC = 5'b11100;

  typedef struct packed {
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, c_out, inport_out;
    logic pc_in, ir_in, y_in, z_in, mdr_in, mar_in, hi_in, lo_in;
    logic [4:0] alu_op;
    logic read, mem_rd, mem_wr, halted, illegal;
  } ctrl_t;

  typedef struct {
    ctrl_t exp;
    string nm;
  } sb_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic clear = 1'b0, run = 1'b0, mem_done = 1'b0;
  logic [31:0] ir = '0;
  logic [15:0] r_out, r_in;
  logic hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, c_out, inport_out;
  logic pc_in, ir_in, y_in, z_in, mdr_in, mar_in, hi_in, lo_in;
  logic [4:0] alu_op;
  logic read, mem_rd, mem_wr, halted, illegal;

  datapath_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_done(mem_done),
    .r_out(r_out), .r_in(r_in),
    .hi_out(hi_out), .lo_out(lo_out), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
    .pc_out(pc_out), .mdr_out(mdr_out), .c_out(c_out), .inport_out(inport_out),
    .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .mdr_in(mdr_in), .mar_in(mar_in), .hi_in(hi_in), .lo_in(lo_in),
    .alu_op(alu_op), .read(read), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .halted(halted), .illegal(illegal)
  );

  ctrl_t act;
  assign act = {r_out, r_in, hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out,
                c_out, inport_out, pc_in, ir_in, y_in, z_in, mdr_in, mar_in, hi_in,
                lo_in, alu_op, read, mem_rd, mem_wr, halted, illegal};

  sb_t sb_q[$];
  sb_t cur;
  int errors = 0;
  int checks = 0;

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s: actual=%h required=%h", cur.nm, act, cur.exp);
      end
      checks++;
      if ($countones({r_out, hi_out, lo_out, zhigh_out, zlow_out, pc_out,
                      mdr_out, c_out, inport_out}) > 1) begin
        errors++;
        $display("FAIL %s.bus_onehot: actual r_out=%h other selects=%b required at most one select",
                 cur.nm, r_out, {hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, c_out, inport_out});
      end
    end
  end

  function automatic logic [31:0] enc(input logic [4:0] op, input int unsigned ra,
                                      input int unsigned rb, input int unsigned rc,
                                      input logic [14:0] c);
    return {op, 4'(ra), 4'(rb), 4'(rc), c};
  endfunction

  function automatic ctrl_t w_zero();
    ctrl_t w = '0;
    return w;
  endfunction
  function automatic ctrl_t w_f0();
    ctrl_t w = '0;
    w.pc_out = 1'b1; w.mar_in = 1'b1; w.z_in = 1'b1; w.alu_op = T_INC;
    return w;
  endfunction
  function automatic ctrl_t w_f1();
    ctrl_t w = '0;
    w.zlow_out = 1'b1; w.pc_in = 1'b1; w.mem_rd = 1'b1;
    return w;
  endfunction
  function automatic ctrl_t w_rd(input logic md);
    ctrl_t w = '0;
    w.mem_rd = 1'b1; w.read = 1'b1; w.mdr_in = md;
    return w;
  endfunction
  function automatic ctrl_t w_f3();
    ctrl_t w = '0;
    w.mdr_out = 1'b1; w.ir_in = 1'b1;
    return w;
  endfunction
  function automatic ctrl_t w_rout_y(input int unsigned r);
    ctrl_t w = '0;
    w.r_out = 16'h0001 << r; w.y_in = 1'b1;
    return w;
  endfunction
  function automatic ctrl_t w_rout_alu(input int unsigned r, input logic [4:0] op);
    ctrl_t w = '0;
    w.r_out = 16'h0001 << r; w.alu_op = op; w.z_in = 1'b1;
    return w;
  endfunction
  function automatic ctrl_t w_c_alu(input logic [4:0] op);
    ctrl_t w = '0;
    w.c_out = 1'b1; w.alu_op = op; w.z_in = 1'b1;
    return w;
  endfunction
  function automatic ctrl_t w_zlow_rin(input int unsigned r);
    ctrl_t w = '0;
    w.zlow_out = 1'b1; w.r_in = 16'h0001 << r;
    return w;
  endfunction
  function automatic ctrl_t w_zlow_mar();
    ctrl_t w = '0;
    w.zlow_out = 1'b1; w.mar_in = 1'b1;
    return w;
  endfunction
  function automatic ctrl_t w_halt(input logic ill);
    ctrl_t w = '0;
    w.halted = 1'b1; w.illegal = ill;
    return w;
  endfunction

  // One clock: inputs for the cycle are applied just after the edge, and the
  // control word expected during that cycle is queued for the monitor.
  task automatic cyc(input ctrl_t e, input string nm, input logic clr,
                     input logic rn, input logic md);
    sb_t s;
    @(posedge clock);
    #1;
    clear = clr; run = rn; mem_done = md;
    s.exp = e; s.nm = nm;
    sb_q.push_back(s);
  endtask

  task automatic ex(input ctrl_t e, input string nm, input logic md);
    cyc(e, nm, 1'b1, 1'b1, md);
  endtask

  task automatic fetch(input string p, input logic [31:0] irv, input int unsigned waits);
    ex(w_f0(), {p, ".F0"}, 1'b0);
    ir = irv;
    ex(w_f1(), {p, ".F1"}, 1'b0);
    for (int unsigned i = 0; i < waits; i++) ex(w_rd(1'b0), {p, ".F2wait"}, 1'b0);
    ex(w_rd(1'b1), {p, ".F2done"}, 1'b1);
    ex(w_f3(), {p, ".F3"}, 1'b0);
  endtask

  initial begin
    ctrl_t w;
    cyc(w_zero(), "reset0", 1'b0, 1'b0, 1'b0);
    cyc(w_zero(), "reset1", 1'b1, 1'b0, 1'b1);
    cyc(w_zero(), "idle_norun", 1'b1, 1'b1, 1'b0);

    // add R3,R1,R2 (Rc=R2 encoded at bits 18:15)
    fetch("add", enc(T_ADD, 3, 1, 2, '0), 0);
    ex(w_rout_y(1), "add.E0", 1'b1);
    ex(w_rout_alu(2, T_ADD), "add.E1", 1'b1);
    ex(w_zlow_rin(3), "add.E2", 1'b1);

    fetch("addi", enc(T_ADDI, 1, 2, 0, 15'd5), 1);
    ex(w_rout_y(2), "addi.E0", 1'b0);
    ex(w_c_alu(T_ADD), "addi.E1", 1'b0);
    ex(w_zlow_rin(1), "addi.E2", 1'b0);

    fetch("andi", enc(T_ANDI, 4, 5, 0, 15'h00ff), 0);
    ex(w_rout_y(5), "andi.E0", 1'b0);
    ex(w_c_alu(T_AND), "andi.E1", 1'b0);
    ex(w_zlow_rin(4), "andi.E2", 1'b0);

    fetch("neg", enc(T_NEG, 7, 8, 0, '0), 0);
    ex(w_rout_alu(8, T_NEG), "neg.E0", 1'b0);
    ex(w_zlow_rin(7), "neg.E2", 1'b0);

    fetch("ld", enc(T_LD, 2, 4, 0, 15'h0010), 0);
    ex(w_rout_y(4), "ld.E0", 1'b0);
    ex(w_c_alu(T_ADD), "ld.E1", 1'b0);
    ex(w_zlow_mar(), "ld.E2", 1'b0);
    for (int i = 0; i < 3; i++) ex(w_rd(1'b0), "ld.M0wait", 1'b0);
    ex(w_rd(1'b1), "ld.M0done", 1'b1);
    w = '0; w.mdr_out = 1'b1; w.r_in = 16'h0004;
    ex(w, "ld.M1", 1'b0);

    fetch("st", enc(T_ST, 5, 6, 0, 15'h0008), 0);
    ex(w_rout_y(6), "st.E0", 1'b0);
    ex(w_c_alu(T_ADD), "st.E1", 1'b0);
    ex(w_zlow_mar(), "st.E2", 1'b1);
    w = '0; w.r_out = 16'h0020; w.mdr_in = 1'b1;
    ex(w, "st.M0", 1'b0);
    w = '0; w.mem_wr = 1'b1;
    ex(w, "st.M1wait", 1'b0);
    ex(w, "st.M1wait", 1'b0);
    ex(w, "st.M1done", 1'b1);

    fetch("nop", enc(T_NOP, 0, 0, 0, '0), 0);
    ex(w_zero(), "nop.E0", 1'b0);

    fetch("mul", enc(T_MUL, 1, 2, 0, '0), 0);
`ifdef SEQ_MULDIV_EN
    ex(w_rout_y(1), "mul.E0", 1'b0);
    ex(w_rout_alu(2, T_MUL), "mul.E1", 1'b0);
    w = '0; w.zlow_out = 1'b1; w.lo_in = 1'b1;
    ex(w, "mul.E2", 1'b0);
    w = '0; w.zhigh_out = 1'b1; w.hi_in = 1'b1;
    ex(w, "mul.E3", 1'b0);
`else
    ex(w_zero(), "mul.E0", 1'b0);
    ex(w_halt(1'b1), "mul.illegal", 1'b1);
    ex(w_halt(1'b1), "mul.illegal", 1'b0);
    cyc(w_halt(1'b1), "mul.illegal_clr", 1'b0, 1'b1, 1'b0);
    cyc(w_zero(), "mul.idle", 1'b1, 1'b1, 1'b0);
`endif

    // Reset while F2 is waiting on memory.
    ex(w_f0(), "clr.F0", 1'b0);
    ex(w_f1(), "clr.F1", 1'b0);
    cyc(w_rd(1'b0), "clr.F2wait", 1'b0, 1'b1, 1'b0);
    cyc(w_zero(), "clr.idle", 1'b1, 1'b1, 1'b1);

    fetch("halt", 32'hD800_0000, 0);
    ex(w_zero(), "halt.E0", 1'b0);
    for (int i = 0; i < 3; i++) ex(w_halt(1'b0), "halt.held", 1'b1);
    cyc(w_halt(1'b0), "halt.clr", 1'b0, 1'b1, 1'b0);
    cyc(w_zero(), "halt.idle", 1'b1, 1'b1, 1'b0);

    fetch("unk", enc(5'b11111, 0, 0, 0, '0), 0);
    ex(w_zero(), "unk.E0", 1'b0);
    ex(w_halt(1'b1), "unk.illegal", 1'b0);
    cyc(w_halt(1'b1), "unk.clr", 1'b0, 1'b0, 1'b0);
    cyc(w_zero(), "unk.idle", 1'b1, 1'b0, 1'b0);
    cyc(w_zero(), "unk.idle_norun", 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d entries left required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
